fib_stream_gen: RTL and testbench
=================================

# fib_stream_gen

Parametrised Fibonacci-sequence stream generator: the successor to the fixed 16-bit single- and double-rate generators. It emits a programmable number of terms from arbitrary seeds, LANES terms per beat, over a valid/ready output stream. It supports wrap or saturating arithmetic and flags overflow. It sits in the sequential-basics block set as a source for downstream stream consumers and testbenches.

## Interface
- WIDTH, 16, bit width of each term (2..64)
- LANES, 2, terms emitted per beat (1..4)
- SATURATE, 0, 0 = modulo-2^WIDTH wrap, 1 = clamp each term to all-ones
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new run; accepted when start && start_ready
- start_ready  out  1  equals !busy
- seed0  in  WIDTH  term x0, sampled on accepted start
- seed1  in  WIDTH  term x1, sampled on accepted start
- count  in  16  number of terms to emit, sampled on accepted start
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH], lane 0 = earliest term
- out_keep  out  LANES  lane k holds a valid term
- out_last  out  1  final beat of the run
- out_overflow  out  1  sticky: some term emitted so far in this run overflowed
- busy  out  1  run in progress

## Operation
- Sequence: x(n+2) = x(n) + x(n+1), computed at WIDTH+1 bits; a term overflows when the carry is set.
- Wrap mode: keep the low WIDTH bits. Saturate mode: an overflowed term becomes 2^WIDTH-1, and every later term therefore saturates.
- State machine has two states, IDLE and RUN.
- IDLE to RUN on accepted start with count != 0: load a=seed0, b=seed1, rem=count, ovf=0.
- Accepted start with count == 0: stays IDLE, emits nothing, clears ovf.
- RUN: a beat carries terms x(i)..x(i+LANES-1), built by a combinational adder chain from a and b.
- keep = lanes k < min(rem, LANES). Non-kept lanes drive 0 on out_data.
- A beat is accepted on out_valid && out_ready. On acceptance: a,b advance to x(i+LANES), x(i+LANES+1); rem -= kept count.
- Overflow is ORed into the sticky flag for kept lanes only.
- out_last = (rem <= LANES). Acceptance of the last beat returns to IDLE.
- start while busy is ignored. Seeds and count are not re-sampled.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, out_overflow=0, busy=0, start_ready=1, state IDLE.
- Start accepted at edge T: busy and out_valid are high after T. The first beat is visible in cycle T+1.
- out_data, out_keep, out_last and out_overflow are registered. They stay stable while out_valid && !out_ready.
- With out_ready held high, throughput is LANES terms per cycle with no bubbles.
- out_overflow is high from the first beat containing an overflowed term through the end of the run. It holds its value in IDLE until the next accepted start.
- After the last beat is accepted at edge E, out_valid and busy are low after E, and start_ready is high in cycle E+1.
- rst mid-run: returns to IDLE and restores reset values at the next edge. A partially delivered run is discarded.

## Structure
- Package fib_pkg holds:
  - state enum (IDLE, RUN)
  - function fib_add(a, b, sat) returning {ovf, sum}, which applies the wrap/clamp rule
  - localparam CNT_W = 16
- Sub-module fib_lane_chain (combinational, parametrised by WIDTH, LANES, SATURATE): given a, b, it produces LANES terms, per-lane overflow bits, and the next a, b.
- fib_stream_gen holds the FSM, the registers and the handshake.

## Test plan
- WIDTH=16, LANES=2, seeds 1,1, count 5, ready high -> three beats:
  - {1,1} keep 11
  - {2,3} keep 11
  - {5,0} keep 01, out_last=1
  - busy low the cycle after.
- Same run with out_ready toggling 1,0,0,1,... -> identical beat sequence, data held stable during stalls, no term lost or duplicated.
- Seeds 1,1, count 26, SATURATE=0 -> beat 12 = {x24=9489, x25=55857}, out_overflow rises on that beat and stays high through out_last.
- Same run, SATURATE=1 -> beat 12 = {65535, 65535}, overflow flagged.
- count=0 start -> no out_valid, busy stays 0.
- start pulsed mid-run -> ignored, output unchanged.
- rst asserted during beat 2 of a count-10 run -> all outputs at reset values next cycle.
- A fresh start with seeds 3,4, count 3, LANES=4 -> single beat {3,4,7,0}, keep 0111, last=1.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and arithmetic for the Fibonacci stream generator.
package fib_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Adds two terms of width w (held in the low bits of 64-bit operands).
  // Returns {ovf, sum}; in saturate mode an overflowed sum clamps to all-ones.
  function automatic logic [64:0] fib_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic        sat,
                                          input logic [6:0]  w);
    logic [64:0] sum;
    logic [63:0] mask;
    sum  = {1'b0, a} + {1'b0, b};
    mask = (w >= 7'd64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sum[w] && sat) return {1'b1, mask};
    return {sum[w], sum[63:0] & mask};
  endfunction

endpackage

// File: rtl/fib_lane_chain.sv
// Combinational adder chain: from the pair (a, b) produce LANES consecutive
// terms, their overflow bits, and the pair that starts the following beat.
module fib_lane_chain
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LANES    = 2,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0]       a_i,
  input  logic [WIDTH-1:0]       b_i,
  input  logic                   a_ovf_i,
  input  logic                   b_ovf_i,
  output logic [LANES*WIDTH-1:0] terms_o,
  output logic [LANES-1:0]       ovf_o,
  output logic [WIDTH-1:0]       next_a_o,
  output logic [WIDTH-1:0]       next_b_o,
  output logic                   next_a_ovf_o,
  output logic                   next_b_ovf_o
);

  logic [WIDTH-1:0] t [LANES+2];
  logic [LANES+1:0] v;
  logic [64:0]      r [2:LANES+1];

  // Unrolled recurrence; overflow of a and b travels with them into the next beat.
  always_comb begin
    t[0] = a_i;
    t[1] = b_i;
    v[0] = a_ovf_i;
    v[1] = b_ovf_i;
    for (int k = 2; k < LANES + 2; k++) begin
      r[k] = fib_add(64'(t[k-2]), 64'(t[k-1]), SATURATE != 0, 7'(WIDTH));
      t[k] = WIDTH'(r[k][63:0]);
      v[k] = r[k][64];
    end
  end

  // Pack the emitted lanes and hand off the continuation pair.
  always_comb begin
    terms_o = '0;
    ovf_o   = '0;
    for (int k = 0; k < LANES; k++) begin
      terms_o[k*WIDTH +: WIDTH] = t[k];
      ovf_o[k]                  = v[k];
    end
    next_a_o     = t[LANES];
    next_b_o     = t[LANES+1];
    next_a_ovf_o = v[LANES];
    next_b_ovf_o = v[LANES+1];
  end

endmodule

// File: rtl/fib_stream_gen.sv
// Fibonacci stream source: LANES terms per beat over valid/ready, with
// registered beat outputs and a sticky overflow flag per run.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold, overflow flag holds last run
//   RUN   | a beat is presented; advances on each accepted beat
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LANES    = 2,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   start_ready,
  input  logic [WIDTH-1:0]       seed0,
  input  logic [WIDTH-1:0]       seed1,
  input  logic [CNT_W-1:0]       count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_last,
  output logic                   out_overflow,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic                   a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]       keep_q, keep_d;
  logic                   last_q, last_d;
  logic                   ovf_q, ovf_d;

  logic                   idle;
  logic [WIDTH-1:0]       src_a, src_b;
  logic                   src_a_ovf, src_b_ovf;
  logic [CNT_W-1:0]       rem_left, src_rem;
  logic [LANES*WIDTH-1:0] terms;
  logic [LANES-1:0]       lane_ovf;
  logic [WIDTH-1:0]       nx_a, nx_b;
  logic                   nx_a_ovf, nx_b_ovf;
  logic [LANES*WIDTH-1:0] beat_data;
  logic [LANES-1:0]       beat_keep;
  logic                   beat_last, beat_ovf;

  // The next beat is built from the seeds when starting, else from the carried pair.
  assign idle      = (state_q == IDLE);
  assign src_a     = idle ? seed0 : a_q;
  assign src_b     = idle ? seed1 : b_q;
  assign src_a_ovf = idle ? 1'b0 : a_ovf_q;
  assign src_b_ovf = idle ? 1'b0 : b_ovf_q;
  assign rem_left  = (rem_q > LANES_C) ? (rem_q - LANES_C) : '0;
  assign src_rem   = idle ? count : rem_left;

  fib_lane_chain #(
    .WIDTH    (WIDTH),
    .LANES    (LANES),
    .SATURATE (SATURATE)
  ) u_chain (
    .a_i          (src_a),
    .b_i          (src_b),
    .a_ovf_i      (src_a_ovf),
    .b_ovf_i      (src_b_ovf),
    .terms_o      (terms),
    .ovf_o        (lane_ovf),
    .next_a_o     (nx_a),
    .next_b_o     (nx_b),
    .next_a_ovf_o (nx_a_ovf),
    .next_b_ovf_o (nx_b_ovf)
  );

  // Lane masking for the candidate beat: only the first min(rem, LANES) lanes count.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_keep[k] = (src_rem > CNT_W'(k));
      if (beat_keep[k]) beat_data[k*WIDTH +: WIDTH] = terms[k*WIDTH +: WIDTH];
    end
    beat_last = (src_rem <= LANES_C);
    beat_ovf  = |(lane_ovf & beat_keep);
  end

  // Next-state and register-load decisions for start and beat acceptance.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    rem_d   = rem_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = RUN;
            a_d     = nx_a;
            b_d     = nx_b;
            a_ovf_d = nx_a_ovf;
            b_ovf_d = nx_b_ovf;
            rem_d   = count;
            data_d  = beat_data;
            keep_d  = beat_keep;
            last_d  = beat_last;
            ovf_d   = beat_ovf;
          end else begin
            ovf_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
          end else begin
            a_d     = nx_a;
            b_d     = nx_b;
            a_ovf_d = nx_a_ovf;
            b_ovf_d = nx_b_ovf;
            rem_d   = rem_left;
            data_d  = beat_data;
            keep_d  = beat_keep;
            last_d  = beat_last;
            ovf_d   = ovf_q | beat_ovf;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and beat registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      rem_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign start_ready  = !busy;
  assign out_valid    = busy;
  assign out_data     = data_q;
  assign out_keep     = keep_q;
  assign out_last     = last_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen: wrap and saturate 2-lane instances share
// stimulus; a 4-lane instance has its own start.
module tb_fib_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start4, out_ready;
  logic [15:0] seed0, seed1, count;

  logic        d2_start_ready, d2_valid, d2_last, d2_ovf, d2_busy;
  logic [31:0] d2_data;
  logic [1:0]  d2_keep;
  logic        s2_start_ready, s2_valid, s2_last, s2_ovf, s2_busy;
  logic [31:0] s2_data;
  logic [1:0]  s2_keep;
  logic        d4_start_ready, d4_valid, d4_last, d4_ovf, d4_busy;
  logic [63:0] d4_data;
  logic [3:0]  d4_keep;

  int n_checks = 0;
  int n_fail   = 0;

  fib_stream_gen #(.WIDTH(16), .LANES(2), .SATURATE(0)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .start_ready(d2_start_ready),
    .seed0(seed0), .seed1(seed1), .count(count),
    .out_valid(d2_valid), .out_ready(out_ready), .out_data(d2_data),
    .out_keep(d2_keep), .out_last(d2_last), .out_overflow(d2_ovf), .busy(d2_busy));

  fib_stream_gen #(.WIDTH(16), .LANES(2), .SATURATE(1)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .start_ready(s2_start_ready),
    .seed0(seed0), .seed1(seed1), .count(count),
    .out_valid(s2_valid), .out_ready(out_ready), .out_data(s2_data),
    .out_keep(s2_keep), .out_last(s2_last), .out_overflow(s2_ovf), .busy(s2_busy));

  fib_stream_gen #(.WIDTH(16), .LANES(4), .SATURATE(0)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .start_ready(d4_start_ready),
    .seed0(seed0), .seed1(seed1), .count(count),
    .out_valid(d4_valid), .out_ready(out_ready), .out_data(d4_data),
    .out_keep(d4_keep), .out_last(d4_last), .out_overflow(d4_ovf), .busy(d4_busy));

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] cnt;
    logic [3:0]  rpat;
    int          first;
    int          n;
  } run_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  keep;
    logic        last;
  } beat_t;

  run_t  runs  [5];
  beat_t beats [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] cnt);
    @(negedge clk);
    seed0 = s0;
    seed1 = s1;
    count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk the expected beats of the 2-lane wrap instance; stalled cycles re-check the held beat.
  task automatic drain(input int first, input int n, input logic [3:0] rpat);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 64) begin
      out_ready = rpat[cyc % 4];
      #1;
      check("valid", 64'(d2_valid), 64'd1);
      if (d2_valid) begin
        check("data", 64'(d2_data), 64'(beats[first+idx].data));
        check("keep", 64'(d2_keep), 64'(beats[first+idx].keep));
        check("last", 64'(d2_last), 64'(beats[first+idx].last));
        check("ovf",  64'(d2_ovf),  64'd0);
      end
      if (d2_valid && out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    if (idx < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", idx, n);
    end
    out_ready = 1'b0;
    #1;
    check("busy_after",  64'(d2_busy),        64'd0);
    check("valid_after", 64'(d2_valid),       64'd0);
    check("ready_after", 64'(d2_start_ready), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 64'(d2_valid),       64'd0);
    check({tag, "_data"},  64'(d2_data),        64'd0);
    check({tag, "_keep"},  64'(d2_keep),        64'd0);
    check({tag, "_last"},  64'(d2_last),        64'd0);
    check({tag, "_ovf"},   64'(d2_ovf),         64'd0);
    check({tag, "_busy"},  64'(d2_busy),        64'd0);
    check({tag, "_rdy"},   64'(d2_start_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    beats[0] = '{32'h0001_0001, 2'b11, 1'b0};
    beats[1] = '{32'h0003_0002, 2'b11, 1'b0};
    beats[2] = '{32'h0000_0005, 2'b01, 1'b1};
    beats[3] = '{32'h0009_0007, 2'b11, 1'b1};
    beats[4] = '{32'h0000_0005, 2'b01, 1'b1};
    beats[5] = '{32'h0014_000A, 2'b11, 1'b0};
    beats[6] = '{32'h0000_001E, 2'b01, 1'b1};

    runs[0] = '{16'd1,  16'd1,  16'd5, 4'b1111, 0, 3};
    runs[1] = '{16'd1,  16'd1,  16'd5, 4'b1001, 0, 3};
    runs[2] = '{16'd7,  16'd9,  16'd2, 4'b1111, 3, 1};
    runs[3] = '{16'd5,  16'd6,  16'd1, 4'b1111, 4, 1};
    runs[4] = '{16'd10, 16'd20, 16'd3, 4'b0101, 5, 2};

    rst = 1'b1; start = 1'b0; start4 = 1'b0; out_ready = 1'b0;
    seed0 = '0; seed1 = '0; count = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    check("reset_d4_valid", 64'(d4_valid), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_start(runs[i].s0, runs[i].s1, runs[i].cnt);
      drain(runs[i].first, runs[i].n, runs[i].rpat);
    end

    // 26 terms from 1,1: first overflow is x24 in beat 12, flag stays up to the end.
    do_start(16'd1, 16'd1, 16'd26);
    out_ready = 1'b1;
    for (int b = 0; b < 13; b++) begin
      #1;
      check("c26_valid", 64'(d2_valid), 64'd1);
      check("c26_ovf_wrap", 64'(d2_ovf), (b >= 12) ? 64'd1 : 64'd0);
      check("c26_ovf_sat",  64'(s2_ovf), (b >= 12) ? 64'd1 : 64'd0);
      check("c26_last", 64'(d2_last), (b == 12) ? 64'd1 : 64'd0);
      if (b == 12) begin
        check("c26_data_wrap", 64'(d2_data), {32'd0, 16'd55857, 16'd9489});
        check("c26_data_sat",  64'(s2_data), {32'd0, 16'hFFFF, 16'hFFFF});
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check("c26_busy_after", 64'(d2_busy), 64'd0);
    check("c26_ovf_hold",   64'(d2_ovf),  64'd1);

    // count == 0: nothing emitted, sticky overflow cleared.
    do_start(16'd5, 16'd5, 16'd0);
    #1;
    check("c0_valid", 64'(d2_valid), 64'd0);
    check("c0_busy",  64'(d2_busy),  64'd0);
    check("c0_ovf",   64'(d2_ovf),   64'd0);
    check("c0_ovf_s", 64'(s2_ovf),   64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("c0_busy_later", 64'(d2_busy), 64'd0);

    // start while busy is ignored.
    do_start(16'd1, 16'd1, 16'd5);
    seed0 = 16'd100; seed1 = 16'd200; count = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("mid_start_data", 64'(d2_data), 64'h0001_0001);
    check("mid_start_busy", 64'(d2_busy), 64'd1);
    drain(0, 3, 4'b1111);

    // Reset while beat 2 of a 10-term run is presented.
    do_start(16'd1, 16'd1, 16'd10);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("rst_beat2_data", 64'(d2_data), 64'h0003_0002);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_vals("midrst");
    rst = 1'b0;

    // Four lanes, three terms: a single partial beat.
    @(negedge clk);
    seed0 = 16'd3; seed1 = 16'd4; count = 16'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    out_ready = 1'b1;
    #1;
    check("l4_valid", 64'(d4_valid), 64'd1);
    check("l4_data",  d4_data, 64'h0000_0007_0004_0003);
    check("l4_keep",  64'(d4_keep), 64'b0111);
    check("l4_last",  64'(d4_last), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("l4_busy_after", 64'(d4_busy), 64'd0);
    check("l4_rdy_after",  64'(d4_start_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
